uart_rx_byte: RTL and testbench

UART receiver that turns the serial line into bytes. It recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from an asynchronous `rx` pin and presents each byte on a valid/ready interface. It detects framing errors and overruns. It is the counterpart of the existing FIFO-to-UART transmit path in TOP and is used to receive host commands on the same link.

---
 rtl/uart_rx_byte.sv | 139 +++++++++++++
 tb/tb_uart_rx_byte.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with a valid/ready byte output.
// It flags framing errors and overruns with single-cycle pulses.
module uart_rx_byte #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_RECOVER
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             sync_1;
    logic             rx_s;

    // Two-flop synchronizer; both flops reset to the idle-high line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= rx;
            rx_s   <= sync_1;
        end
    end

    // Frame state machine, bit timing, and the registered output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            count      <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    count   <= '0;
                    bit_idx <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                    end
                end

                S_START: begin
                    if (count == HALF_END) begin
                        count   <= '0;
                        bit_idx <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                S_DATA: begin
                    if (count == BIT_END) begin
                        count     <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                S_STOP: begin
                    if (count == BIT_END) begin
                        count <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                            if (!data_valid || data_ready) begin
                                data_out   <= shift_reg;
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_RECOVER;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                S_RECOVER: begin
                    count <= '0;
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed and randomized frames on the serial line.
// Expected bytes and event counts come from a frame-level model of the link.
module tb_uart_rx_byte;

    localparam int CPB        = 434;
    localparam int FRAME_LAT  = 2 + 217 + 9 * CPB;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;

    int tests;
    int fails;
    int cyc;
    int last_t0;

    logic [7:0] got_q[$];
    int         rise_q[$];
    int         valid_hi;
    int         fe_hi;
    int         ov_hi;
    int         ov_last;
    logic       prev_valid;

    int b_got;
    int b_rise;
    int b_vhi;
    int b_fe;
    int b_ov;

    logic [7:0] exp_q[$];
    int         exp_fe;

    uart_rx_byte dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used as the time base for latency checks
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor sampling on the falling edge, away from the active edge
    initial begin
        valid_hi   = 0;
        fe_hi      = 0;
        ov_hi      = 0;
        ov_last    = 0;
        prev_valid = 1'b0;
    end
    always @(negedge clk) begin
        if (data_valid && !prev_valid) rise_q.push_back(cyc);
        if (data_valid) valid_hi = valid_hi + 1;
        if (data_valid && data_ready) got_q.push_back(data_out);
        if (frame_err) fe_hi = fe_hi + 1;
        if (overrun) begin
            ov_hi   = ov_hi + 1;
            ov_last = cyc;
        end
        prev_valid = data_valid;
    end

    // Watchdog so the run can never hang
    initial begin
        repeat (99000) @(posedge clk);
        $display("[TB] FAIL watchdog: cycle budget exhausted, got %0d expected < 99000", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests = tests + 1;
        if (observed !== expected) begin
            fails = fails + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] gotAt(input int idx);
        if (idx < got_q.size()) return {24'd0, got_q[idx]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic mark();
        b_got  = got_q.size();
        b_rise = rise_q.size();
        b_vhi  = valid_hi;
        b_fe   = fe_hi;
        b_ov   = ov_hi;
    endtask

    // Drives one full 8N1 frame; returns at the end of the stop bit
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input int bit_clks);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            rx = bits[i];
            if (i == 0) last_t0 = cyc + 1;
            repeat (bit_clks - 1) @(posedge clk);
        end
    endtask

    task automatic idleLine(input int n);
        @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        last_t0    = 0;
        exp_fe     = 0;
        rx         = 1'b1;
        data_ready = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", {31'd0, data_valid}, 32'd0);
        checkOutput("reset_data", {24'd0, data_out}, 32'd0);
        checkOutput("reset_ferr", {31'd0, frame_err}, 32'd0);
        checkOutput("reset_ovr", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        idleLine(20);

        // Single byte with exact latency
        data_ready = 1'b1;
        mark();
        applyStimulus(8'h55, 1'b1, CPB);
        idleLine(50);
        checkOutput("single_count", got_q.size() - b_got, 1);
        checkOutput("single_data", gotAt(b_got), 32'h55);
        checkOutput("single_latency", (rise_q.size() > b_rise) ? rise_q[b_rise] - last_t0 : -1, FRAME_LAT);
        checkOutput("single_valid_width", valid_hi - b_vhi, 1);
        checkOutput("single_ferr", fe_hi - b_fe, 0);
        checkOutput("single_ovr", ov_hi - b_ov, 0);

        // Back-to-back frames with no idle gap
        mark();
        applyStimulus(8'hA3, 1'b1, CPB);
        applyStimulus(8'h0F, 1'b1, CPB);
        idleLine(50);
        checkOutput("b2b_count", got_q.size() - b_got, 2);
        checkOutput("b2b_first", gotAt(b_got), 32'hA3);
        checkOutput("b2b_second", gotAt(b_got + 1), 32'h0F);
        checkOutput("b2b_spacing", (rise_q.size() > b_rise + 1) ? rise_q[b_rise + 1] - rise_q[b_rise] : -1, 10 * CPB);

        // Short low glitch is rejected silently
        mark();
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (99) @(posedge clk);
        idleLine(400);
        checkOutput("glitch_valid", rise_q.size() - b_rise, 0);
        checkOutput("glitch_ferr", fe_hi - b_fe, 0);

        // Framing error followed by a long break, then a good frame
        mark();
        applyStimulus(8'hFF, 1'b0, CPB);
        repeat (5000) @(posedge clk);
        checkOutput("break_ferr", fe_hi - b_fe, 1);
        checkOutput("break_valid", rise_q.size() - b_rise, 0);
        idleLine(CPB);
        applyStimulus(8'h3C, 1'b1, CPB);
        idleLine(50);
        checkOutput("after_break_count", got_q.size() - b_got, 1);
        checkOutput("after_break_data", gotAt(b_got), 32'h3C);
        checkOutput("after_break_ferr", fe_hi - b_fe, 1);

        // Overrun: second byte dropped while the first waits
        data_ready = 1'b0;
        mark();
        applyStimulus(8'h11, 1'b1, CPB);
        applyStimulus(8'h22, 1'b1, CPB);
        idleLine(50);
        checkOutput("ovr_valid_held", {31'd0, data_valid}, 32'd1);
        checkOutput("ovr_data_kept", {24'd0, data_out}, 32'h11);
        checkOutput("ovr_pulse", ov_hi - b_ov, 1);
        checkOutput("ovr_timing", ov_last - last_t0, FRAME_LAT);
        checkOutput("ovr_no_transfer", got_q.size() - b_got, 0);
        @(posedge clk);
        #1;
        data_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("ovr_drain_count", got_q.size() - b_got, 1);
        checkOutput("ovr_drain_data", gotAt(b_got), 32'h11);
        checkOutput("ovr_drain_valid", {31'd0, data_valid}, 32'd0);

        // Reset in the middle of a frame while a byte is pending
        data_ready = 1'b0;
        mark();
        applyStimulus(8'h77, 1'b1, CPB);
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (5 * CPB + 200) @(posedge clk);
        #1;
        checkOutput("pre_reset_valid", {31'd0, data_valid}, 32'd1);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        checkOutput("mid_reset_valid", {31'd0, data_valid}, 32'd0);
        checkOutput("mid_reset_data", {24'd0, data_out}, 32'd0);
        checkOutput("mid_reset_ferr", {31'd0, frame_err}, 32'd0);
        checkOutput("mid_reset_ovr", {31'd0, overrun}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        data_ready = 1'b1;
        idleLine(CPB);
        applyStimulus(8'h5A, 1'b1, CPB);
        idleLine(50);
        checkOutput("post_reset_count", got_q.size() - b_got, 1);
        checkOutput("post_reset_data", gotAt(b_got), 32'h5A);
        checkOutput("post_reset_ferr", fe_hi - b_fe, 0);

        // Randomized frames with small baud mismatch and occasional bad stop bits
        mark();
        exp_q.delete();
        exp_fe = 0;
        for (int n = 0; n < 5; n++) begin
            logic [7:0] b;
            logic       bad;
            int         bc;
            int         gap;
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            bc  = $urandom_range(424, 444);
            applyStimulus(b, !bad, bc);
            if (bad) begin
                exp_fe = exp_fe + 1;
                gap    = bc + $urandom_range(0, 40);
            end else begin
                exp_q.push_back(b);
                gap = $urandom_range(0, 40);
            end
            if (gap > 0) idleLine(gap);
        end
        idleLine(50);
        checkOutput("rand_count", got_q.size() - b_got, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checkOutput($sformatf("rand_byte%0d", i), gotAt(b_got + i), {24'd0, exp_q[i]});
        end
        checkOutput("rand_ferr", fe_hi - b_fe, exp_fe);
        checkOutput("rand_ovr", ov_hi - b_ov, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
